// File: rtl/even_odd_frame_sorter_pkg.sv
// rtl/even_odd_frame_sorter_pkg.sv - shared types and defaults for the even/odd frame sorter
//
// Purpose: frame scheduler state encoding and default widths.
//   ST_IDLE  : waiting for start
//   ST_RUN   : accepting numbers until the frame count is exhausted
//   ST_DRAIN : input closed, waiting for both holding registers to empty
//   ST_DONE  : one-cycle completion state

package even_odd_frame_sorter_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/even_odd_frame_sorter_even_odd_check.sv
// rtl/even_odd_frame_sorter_even_odd_check.sv - combinational parity classifier
//
// Purpose: classify an unsigned number as even or odd from its LSB.
// Ports:
//   num  in   DATA_W  number to classify
//   even out  1       num is even
//   odd  out  1       num is odd

module even_odd_check
  import even_odd_frame_sorter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] num,
  output logic              even,
  output logic              odd
);

  // Masking keeps only bit 0 while still consuming the whole operand.
  logic [DATA_W-1:0] lsb_only;

  always_comb begin
    lsb_only = num & DATA_W'(1);
    odd      = |lsb_only;
    even     = ~odd;
  end

endmodule

// File: rtl/even_odd_frame_sorter.sv
// rtl/even_odd_frame_sorter.sv - frame scheduler routing numbers to even/odd channels
//
// Purpose: accept a frame of frame_len numbers, route each into an even or odd
// one-entry holding register, count per class, pulse done at completion.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   start, frame_len               frame request (sampled in IDLE only)
//   busy                           state != IDLE
//   in_valid, in_data, in_ready    number input stream
//   even_valid/data/ready          even output channel
//   odd_valid/data/ready           odd output channel
//   even_cnt, odd_cnt              per-class counts for current/last frame
//   done                           one-cycle completion pulse

module even_odd_frame_sorter
  import even_odd_frame_sorter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  frame_len,
  output logic              busy,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              even_valid,
  output logic [DATA_W-1:0] even_data,
  input  logic              even_ready,
  output logic              odd_valid,
  output logic [DATA_W-1:0] odd_data,
  input  logic              odd_ready,
  output logic [CNT_W-1:0]  even_cnt,
  output logic [CNT_W-1:0]  odd_cnt,
  output logic              done
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              even_valid_q, even_valid_d;
  logic [DATA_W-1:0] even_data_q, even_data_d;
  logic              odd_valid_q, odd_valid_d;
  logic [DATA_W-1:0] odd_data_q, odd_data_d;
  logic [CNT_W-1:0]  even_cnt_q, even_cnt_d;
  logic [CNT_W-1:0]  odd_cnt_q, odd_cnt_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic chk_even, chk_odd;
  logic even_free, odd_free, accept;

  even_odd_check #(.DATA_W(DATA_W)) u_check (
    .num  (in_data),
    .even (chk_even),
    .odd  (chk_odd)
  );

  // A slot is free if empty or being drained this cycle. in_ready requires
  // both free so acceptance never depends on the value being offered.
  assign even_free = !even_valid_q || even_ready;
  assign odd_free  = !odd_valid_q  || odd_ready;
  assign in_ready  = (state_q == ST_RUN) && even_free && odd_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    even_valid_d = even_valid_q;
    even_data_d  = even_data_q;
    odd_valid_d  = odd_valid_q;
    odd_data_d   = odd_data_q;
    even_cnt_d   = even_cnt_q;
    odd_cnt_d    = odd_cnt_q;

    if (even_valid_q && even_ready) even_valid_d = 1'b0;
    if (odd_valid_q && odd_ready)   odd_valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = frame_len;
          even_cnt_d  = '0;
          odd_cnt_d   = '0;
          state_d     = (frame_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          // A refill overrides the drain above, keeping valid high.
          if (chk_even) begin
            even_valid_d = 1'b1;
            even_data_d  = in_data;
            even_cnt_d   = even_cnt_q + CNT_W'(1);
          end else if (chk_odd) begin
            odd_valid_d  = 1'b1;
            odd_data_d   = in_data;
            odd_cnt_d    = odd_cnt_q + CNT_W'(1);
          end
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (even_free && odd_free) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered status outputs track the state being entered.
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      even_valid_q <= 1'b0;
      even_data_q  <= '0;
      odd_valid_q  <= 1'b0;
      odd_data_q   <= '0;
      even_cnt_q   <= '0;
      odd_cnt_q    <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      even_valid_q <= even_valid_d;
      even_data_q  <= even_data_d;
      odd_valid_q  <= odd_valid_d;
      odd_data_q   <= odd_data_d;
      even_cnt_q   <= even_cnt_d;
      odd_cnt_q    <= odd_cnt_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign even_valid = even_valid_q;
  assign even_data  = even_data_q;
  assign odd_valid  = odd_valid_q;
  assign odd_data   = odd_data_q;
  assign even_cnt   = even_cnt_q;
  assign odd_cnt    = odd_cnt_q;

endmodule

// File: tb/tb_even_odd_frame_sorter.sv
// tb/tb_even_odd_frame_sorter.sv - self-checking bench for even_odd_frame_sorter

module tb_even_odd_frame_sorter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] frame_len;
  logic       busy;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       even_valid;
  logic [7:0] even_data;
  logic       even_ready;
  logic       odd_valid;
  logic [7:0] odd_data;
  logic       odd_ready;
  logic [7:0] even_cnt;
  logic [7:0] odd_cnt;
  logic       done;

  even_odd_frame_sorter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_len  (frame_len),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .even_valid (even_valid),
    .even_data  (even_data),
    .even_ready (even_ready),
    .odd_valid  (odd_valid),
    .odd_data   (odd_data),
    .odd_ready  (odd_ready),
    .even_cnt   (even_cnt),
    .odd_cnt    (odd_cnt),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         exp_even;
  } vec_t;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         done_cnt = 0;
  bit         prev_done = 0;
  bit         odd_seen = 0;
  bit         rand_rdy = 0;
  vec_t       stim_q[$];
  logic [7:0] exp_even_q[$];
  logic [7:0] exp_odd_q[$];
  vec_t       tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output-side scoreboard: every handshake on a channel pops the oldest expected value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (even_valid && even_ready) begin
        if (exp_even_q.size() == 0) check("even_extra", {24'd0, even_data}, 32'hFFFF_FFFF);
        else check("even_sb", {24'd0, even_data}, {24'd0, exp_even_q.pop_front()});
      end
      if (odd_valid && odd_ready) begin
        if (exp_odd_q.size() == 0) check("odd_extra", {24'd0, odd_data}, 32'hFFFF_FFFF);
        else check("odd_sb", {24'd0, odd_data}, {24'd0, exp_odd_q.pop_front()});
      end
      if (done) begin
        done_cnt++;
        if (prev_done) check("done_width", 32'd2, 32'd1);
      end
      if (odd_valid) odd_seen = 1;
      prev_done = done;
    end else begin
      prev_done = 0;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      even_ready = 1'($urandom_range(0, 1));
      odd_ready  = 1'($urandom_range(0, 1));
    end
  end

  task automatic start_frame(input int len);
    @(posedge clk); #1;
    start = 1'b1;
    frame_len = 8'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives stim_q in order; expected values are pushed at acceptance and the
  // one-cycle accept-to-valid latency is checked at the following negedge.
  task automatic send_items(output int stalls);
    vec_t cur;
    int   guard = 0;
    stalls = 0;
    if (stim_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = stim_q[0].data;
    end
    @(negedge clk);
    while (stim_q.size() > 0) begin
      guard++;
      if (guard > 2000) begin
        check("send_timeout", 32'(stim_q.size()), 32'd0);
        break;
      end
      if (in_ready) begin
        cur = stim_q.pop_front();
        if (cur.exp_even) exp_even_q.push_back(cur.data);
        else exp_odd_q.push_back(cur.data);
        @(posedge clk); #1;
        if (stim_q.size() > 0) in_data = stim_q[0].data;
        else in_valid = 1'b0;
        @(negedge clk);
        if (cur.exp_even) begin
          check("lat_even_valid", {31'd0, even_valid}, 32'd1);
          check("lat_even_data", {24'd0, even_data}, {24'd0, cur.data});
        end else begin
          check("lat_odd_valid", {31'd0, odd_valid}, 32'd1);
          check("lat_odd_data", {24'd0, odd_data}, {24'd0, cur.data});
        end
      end else begin
        stalls++;
        @(posedge clk); #1;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_e, input int exp_o);
    int guard = 0;
    while (!done && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("even_cnt", {24'd0, even_cnt}, 32'(exp_e));
    check("odd_cnt", {24'd0, odd_cnt}, 32'(exp_o));
    check("done_even_empty", {31'd0, even_valid}, 32'd0);
    check("done_odd_empty", {31'd0, odd_valid}, 32'd0);
    check("sb_even_drained", 32'(exp_even_q.size()), 32'd0);
    check("sb_odd_drained", 32'(exp_odd_q.size()), 32'd0);
  endtask

  initial begin
    int stalls;
    int ne, no, d0;

    tbl[0] = '{8'd0,   1'b1};
    tbl[1] = '{8'd1,   1'b0};
    tbl[2] = '{8'd6,   1'b1};
    tbl[3] = '{8'd7,   1'b0};
    tbl[4] = '{8'hFE,  1'b1};
    tbl[5] = '{8'hFF,  1'b0};
    tbl[6] = '{8'h80,  1'b1};
    tbl[7] = '{8'h7F,  1'b0};

    // Reset with start/in_valid asserted.
    rst_n = 1'b0; start = 1'b1; frame_len = 8'd3;
    in_valid = 1'b1; in_data = 8'd7; even_ready = 1'b1; odd_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_even_valid", {31'd0, even_valid}, 32'd0);
    check("rst_odd_valid", {31'd0, odd_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_even_cnt", {24'd0, even_cnt}, 32'd0);
    check("rst_odd_cnt", {24'd0, odd_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;

    // Table frame 0,1,6,7 back-to-back with both consumers ready.
    ne = 0; no = 0;
    for (int i = 0; i < 4; i++) begin
      stim_q.push_back(tbl[i]);
      if (tbl[i].exp_even) ne++; else no++;
    end
    d0 = done_cnt;
    start_frame(4);
    send_items(stalls);
    check("t2_stalls", 32'(stalls), 32'd0);
    wait_done(ne, no);
    repeat (3) @(negedge clk);
    check("t2_done_once", 32'(done_cnt - d0), 32'd1);
    check("t2_idle", {31'd0, busy}, 32'd0);

    // Zero-length frame.
    start_frame(0);
    @(negedge clk);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd1);
    check("t4_in_ready", {31'd0, in_ready}, 32'd0);
    check("t4_even_cnt", {24'd0, even_cnt}, 32'd0);
    check("t4_odd_cnt", {24'd0, odd_cnt}, 32'd0);
    @(negedge clk);
    check("t4_done_low", {31'd0, done}, 32'd0);
    check("t4_busy_low", {31'd0, busy}, 32'd0);

    // Odd consumer stalled: 3 held, 5 back-pressured.
    odd_ready = 1'b0;
    stim_q.push_back('{8'd3, 1'b0});
    stim_q.push_back('{8'd5, 1'b0});
    start_frame(2);
    fork
      send_items(stalls);
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          check("t3_hold_valid", {31'd0, odd_valid}, 32'd1);
          check("t3_hold_data", {24'd0, odd_data}, 32'd3);
          check("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
          check("t3_no_done", {31'd0, done}, 32'd0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        odd_ready = 1'b1;
      end
    join
    wait_done(0, 2);

    // Second table frame under random back-pressure.
    ne = 0; no = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        stim_q.push_back(tbl[i]);
        if (tbl[i].exp_even) ne++; else no++;
      end
    end
    start_frame(24);
    rand_rdy = 1;
    send_items(stalls);
    rand_rdy = 0;
    @(posedge clk); #2;
    even_ready = 1'b1; odd_ready = 1'b1;
    wait_done(ne, no);

    // start re-asserted mid-RUN is ignored.
    stim_q.push_back('{8'd2, 1'b1});
    stim_q.push_back('{8'd9, 1'b0});
    start_frame(4);
    send_items(stalls);
    @(posedge clk); #1;
    start = 1'b1; frame_len = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    stim_q.push_back('{8'd4, 1'b1});
    stim_q.push_back('{8'd11, 1'b0});
    send_items(stalls);
    wait_done(2, 2);

    // Reset mid-frame discards held data and never reports done.
    even_ready = 1'b0;
    stim_q.push_back('{8'd8, 1'b1});
    start_frame(5);
    send_items(stalls);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_even_q.delete();
    exp_odd_q.delete();
    even_ready = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_even_valid", {31'd0, even_valid}, 32'd0);
    check("t5_rst_even_data", {24'd0, even_data}, 32'd0);
    check("t5_rst_even_cnt", {24'd0, even_cnt}, 32'd0);
    check("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);

    // Max-length frame, all even.
    odd_seen = 0;
    for (int i = 0; i < 255; i++) stim_q.push_back('{8'hFE, 1'b1});
    start_frame(255);
    send_items(stalls);
    check("t6_stalls", 32'(stalls), 32'd0);
    wait_done(255, 0);
    check("t6_odd_never", {31'd0, odd_seen}, 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
